// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer for a Mini-SRC datapath.
// Optional macro CU_MEM_TIMEOUT_EN bounds Mem_ready waits and enters FAULT.
module control_sequencer #(
    parameter int OPW         = 5,
    parameter int MD_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    input  logic        Con_FF,
    input  logic        Mem_ready,
    output logic [2:0]  Gsel,
    output logic        RIn,
    output logic        Rout,
    output logic        BAout,
    output logic [9:0]  LdEn,
    output logic [7:0]  BusSel,
    output logic [3:0]  AluOp,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Run,
    output logic        Fault
);

    localparam int CMAX = (MD_CYCLES > MEM_TIMEOUT) ? MD_CYCLES : MEM_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_F0    = 4'd1;
    localparam logic [3:0] S_F1    = 4'd2;
    localparam logic [3:0] S_F2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;
    localparam logic [3:0] S_FAULT = 4'd10;

    localparam logic [4:0] C_NOP  = 5'd0;
    localparam logic [4:0] C_ALU  = 5'd1;
    localparam logic [4:0] C_IMM  = 5'd2;
    localparam logic [4:0] C_SHF  = 5'd3;
    localparam logic [4:0] C_MD   = 5'd4;
    localparam logic [4:0] C_UN   = 5'd5;
    localparam logic [4:0] C_LD   = 5'd6;
    localparam logic [4:0] C_LDI  = 5'd7;
    localparam logic [4:0] C_ST   = 5'd8;
    localparam logic [4:0] C_BR   = 5'd9;
    localparam logic [4:0] C_JR   = 5'd10;
    localparam logic [4:0] C_JAL  = 5'd11;
    localparam logic [4:0] C_IN   = 5'd12;
    localparam logic [4:0] C_OUT  = 5'd13;
    localparam logic [4:0] C_MFHI = 5'd14;
    localparam logic [4:0] C_MFLO = 5'd15;
    localparam logic [4:0] C_HALT = 5'd16;

    logic [3:0]    state;
    logic [3:0]    state_n;
    logic [CW-1:0] cnt;
    logic [4:0]    cls;
    logic [3:0]    alu;
    logic [31:0]   opc;
    logic [3:0]    to_f0;
    logic [3:0]    wait_n;
    logic          md_last;
    logic          unused_ir;

    logic mar_in, pc_in, mdr_in, ir_in, y_in;
    logic hi_in, lo_in, z_in, con_in, out_in;
    logic pc_out, zlo_out, zhi_out, mdr_out;
    logic c_out, inp_out, lo_out, hi_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic inc_pc, rd, wr;
    logic [3:0] alu_op;

    assign opc       = 32'(IR[31:32-OPW]);
    assign unused_ir = ^IR[31-OPW:0];
    assign to_f0     = Stop ? S_IDLE : S_F0;
    assign md_last   = (cnt == CW'(MD_CYCLES - 1));

`ifdef CU_MEM_TIMEOUT_EN
    assign wait_n = (cnt == CW'(MEM_TIMEOUT - 1)) ? S_FAULT : state;
    assign Fault  = (state == S_FAULT);
`else
    assign wait_n = state;
    assign Fault  = 1'b0;
`endif

    // Classify the opcode into an execution pattern and ALU function.
    always_comb begin
        cls = C_NOP;
        alu = 4'd0;
        case (opc)
            0:  cls = C_LD;
            1:  cls = C_LDI;
            2:  cls = C_ST;
            3:  begin cls = C_ALU; alu = 4'd1;  end
            4:  begin cls = C_ALU; alu = 4'd2;  end
            5:  begin cls = C_SHF; alu = 4'd5;  end
            6:  begin cls = C_SHF; alu = 4'd6;  end
            7:  begin cls = C_SHF; alu = 4'd7;  end
            8:  begin cls = C_SHF; alu = 4'd8;  end
            9:  begin cls = C_ALU; alu = 4'd3;  end
            10: begin cls = C_ALU; alu = 4'd4;  end
            11: begin cls = C_IMM; alu = 4'd1;  end
            12: begin cls = C_IMM; alu = 4'd3;  end
            13: begin cls = C_IMM; alu = 4'd4;  end
            14: begin cls = C_MD;  alu = 4'd9;  end
            15: begin cls = C_MD;  alu = 4'd10; end
            16: begin cls = C_UN;  alu = 4'd11; end
            17: begin cls = C_UN;  alu = 4'd12; end
            18: cls = C_BR;
            19: cls = C_JR;
            20: cls = C_JAL;
            21: cls = C_IN;
            22: cls = C_OUT;
            23: cls = C_MFHI;
            24: cls = C_MFLO;
            26: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

    // Step sequencing; every instruction ends through to_f0 so Stop is honoured there.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = Stop ? S_IDLE : S_F0;
            S_F0:   state_n = S_F1;
            S_F1:   state_n = Mem_ready ? S_F2 : wait_n;
            S_F2:   state_n = S_T3;
            S_T3: begin
                case (cls)
                    C_HALT: state_n = S_HALT;
                    C_BR:   state_n = Con_FF ? S_T4 : to_f0;
                    C_ALU, C_IMM, C_SHF, C_MD, C_UN,
                    C_LD, C_LDI, C_ST, C_JAL: state_n = S_T4;
                    default: state_n = to_f0;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_MD: state_n = md_last ? S_T5 : S_T4;
                    C_ALU, C_IMM, C_SHF, C_LD,
                    C_LDI, C_ST, C_BR: state_n = S_T5;
                    default: state_n = to_f0;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_MD, C_LD, C_ST, C_BR: state_n = S_T6;
                    default: state_n = to_f0;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:    state_n = Mem_ready ? S_T7 : wait_n;
                    C_ST:    state_n = S_T7;
                    default: state_n = to_f0;
                endcase
            end
            S_T7: begin
                if (cls == C_ST && !Mem_ready)
                    state_n = wait_n;
                else
                    state_n = to_f0;
            end
            S_HALT:  state_n = S_HALT;
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase
    end

    // State and per-step cycle counter (saturating so long waits never wrap).
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    // Control strobes decoded from the held state, step count and opcode.
    always_comb begin
        mar_in = 1'b0; pc_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0;
        y_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; z_in = 1'b0;
        con_in = 1'b0; out_in = 1'b0;
        pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; mdr_out = 1'b0;
        c_out = 1'b0; inp_out = 1'b0; lo_out = 1'b0; hi_out = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
        inc_pc = 1'b0; rd = 1'b0; wr = 1'b0;
        alu_op = 4'd0;
        case (state)
            S_F0: begin pc_out = 1'b1; mar_in = 1'b1; end
            S_F1: begin
                rd = 1'b1; mdr_in = 1'b1;
                inc_pc = (cnt == '0);
            end
            S_F2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM, C_SHF, C_MD: begin
                        grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                    end
                    C_UN: begin
                        grb = 1'b1; r_out = 1'b1; alu_op = alu; z_in = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                    end
                    C_BR:   begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
                    C_JR:   begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                    C_JAL:  begin pc_out = 1'b1; r_in = 1'b1; end
                    C_IN:   begin inp_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_OUT:  begin gra = 1'b1; r_out = 1'b1; out_in = 1'b1; end
                    C_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU: begin
                        grc = 1'b1; r_out = 1'b1; alu_op = alu; z_in = 1'b1;
                    end
                    C_IMM, C_SHF: begin
                        c_out = 1'b1; alu_op = alu; z_in = 1'b1;
                    end
                    C_MD: begin alu_op = alu; z_in = md_last; end
                    C_UN: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_LD, C_LDI, C_ST: begin
                        c_out = 1'b1; alu_op = 4'd1; z_in = 1'b1;
                    end
                    C_BR:  begin pc_out = 1'b1; y_in = 1'b1; end
                    C_JAL: begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_SHF, C_LDI: begin
                        zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                    C_MD:       begin zlo_out = 1'b1; lo_in = 1'b1; end
                    C_LD, C_ST: begin zlo_out = 1'b1; mar_in = 1'b1; end
                    C_BR: begin c_out = 1'b1; alu_op = 4'd1; z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin rd = 1'b1; mdr_in = 1'b1; end
                    C_ST: begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                    C_MD: begin zhi_out = 1'b1; hi_in = 1'b1; end
                    C_BR: begin zlo_out = 1'b1; pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_ST: begin mdr_out = 1'b1; wr = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign Gsel   = {gra, grb, grc};
    assign RIn    = r_in;
    assign Rout   = r_out;
    assign BAout  = ba_out;
    assign LdEn   = {mar_in, pc_in, mdr_in, ir_in, y_in,
                     hi_in, lo_in, z_in, con_in, out_in};
    assign BusSel = {pc_out, zlo_out, zhi_out, mdr_out,
                     c_out, inp_out, lo_out, hi_out};
    assign AluOp  = alu_op;
    assign IncPC  = inc_pc;
    assign Read   = rd;
    assign Write  = wr;
    assign Run    = !(state == S_IDLE || state == S_HALT || state == S_FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-step bench for control_sequencer.
// Expected strobe words are hand-built from the instruction step tables.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [31:0] IR;
    logic        Stop, Con_FF, Mem_ready;
    logic [2:0]  Gsel;
    logic        RIn, Rout, BAout;
    logic [9:0]  LdEn;
    logic [7:0]  BusSel;
    logic [3:0]  AluOp;
    logic        IncPC, Read, Write, Run, Fault;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
        .Con_FF(Con_FF), .Mem_ready(Mem_ready), .Gsel(Gsel),
        .RIn(RIn), .Rout(Rout), .BAout(BAout), .LdEn(LdEn),
        .BusSel(BusSel), .AluOp(AluOp), .IncPC(IncPC), .Read(Read),
        .Write(Write), .Run(Run), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    localparam logic [9:0] L_MAR = 10'h200, L_PC = 10'h100, L_MDR = 10'h080;
    localparam logic [9:0] L_IR  = 10'h040, L_Y  = 10'h020, L_HI  = 10'h010;
    localparam logic [9:0] L_LO  = 10'h008, L_Z  = 10'h004, L_CON = 10'h002;
    localparam logic [7:0] B_PC  = 8'h80, B_ZLO = 8'h40, B_ZHI = 8'h20;
    localparam logic [7:0] B_MDR = 8'h10, B_C   = 8'h08, B_HI  = 8'h01;
    localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
    localparam logic [2:0] R_IN = 3'b100, R_OUT = 3'b010, R_BA = 3'b001;
    localparam logic [2:0] M_INC = 3'b100, M_RD = 3'b010, M_WR = 3'b001;

    logic [32:0] obs;
    assign obs = {Gsel, RIn, Rout, BAout, LdEn, BusSel, AluOp,
                  IncPC, Read, Write, Run, Fault};

    function automatic logic [32:0] ev(input logic [2:0] g, input logic [2:0] rr,
                                       input logic [9:0] ld, input logic [7:0] bs,
                                       input logic [3:0] alu, input logic [2:0] mem);
        return {g, rr, ld, bs, alu, mem, 1'b1, 1'b0};
    endfunction

    function automatic logic [31:0] ins(input logic [4:0] op);
        return {op, 27'h0};
    endfunction

    task automatic chk(input string tag, input logic [32:0] e);
        checks++;
        assert (obs === e) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %09h expected %09h", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic sc(input string tag, input logic [32:0] e);
        step();
        chk(tag, e);
    endtask

    task automatic fetch(input string tag);
        sc({tag, "_f1"}, ev(0, 0, L_MDR, 0, 0, M_INC | M_RD));
        sc({tag, "_f2"}, ev(0, 0, L_IR, B_MDR, 0, 0));
    endtask

    initial begin
        Reset_n = 1'b0; Stop = 1'b0; Con_FF = 1'b0;
        Mem_ready = 1'b1; IR = ins(5'd3);
        step(); step();
        chk("reset", 33'h0);
        Reset_n = 1'b1;
        sc("first_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // add R1,R2,R3
        fetch("add");
        sc("add_t3", ev(GB, R_OUT, L_Y, 0, 0, 0));
        sc("add_t4", ev(GC, R_OUT, L_Z, 0, 4'd1, 0));
        sc("add_t5", ev(GA, R_IN, 0, B_ZLO, 0, 0));
        sc("add_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // ld with three not-ready cycles in T6
        IR = ins(5'd0);
        fetch("ld");
        sc("ld_t3", ev(GB, R_BA, L_Y, 0, 0, 0));
        sc("ld_t4", ev(0, 0, L_Z, B_C, 4'd1, 0));
        sc("ld_t5", ev(0, 0, L_MAR, B_ZLO, 0, 0));
        Mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            sc("ld_t6", ev(0, 0, L_MDR, 0, 0, M_RD));
        Mem_ready = 1'b1;
        sc("ld_t7", ev(GA, R_IN, 0, B_MDR, 0, 0));
        sc("ld_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // mul with a two-cycle F1 wait
        IR = ins(5'd14);
        Mem_ready = 1'b0;
        sc("mul_f1a", ev(0, 0, L_MDR, 0, 0, M_INC | M_RD));
        sc("mul_f1b", ev(0, 0, L_MDR, 0, 0, M_RD));
        Mem_ready = 1'b1;
        sc("mul_f2", ev(0, 0, L_IR, B_MDR, 0, 0));
        sc("mul_t3", ev(GB, R_OUT, L_Y, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            sc("mul_t4", ev(0, 0, 0, 0, 4'd9, 0));
        sc("mul_t4z", ev(0, 0, L_Z, 0, 4'd9, 0));
        sc("mul_t5", ev(0, 0, L_LO, B_ZLO, 0, 0));
        sc("mul_t6", ev(0, 0, L_HI, B_ZHI, 0, 0));
        sc("mul_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // st
        IR = ins(5'd2);
        fetch("st");
        sc("st_t3", ev(GB, R_BA, L_Y, 0, 0, 0));
        sc("st_t4", ev(0, 0, L_Z, B_C, 4'd1, 0));
        sc("st_t5", ev(0, 0, L_MAR, B_ZLO, 0, 0));
        sc("st_t6", ev(GA, R_OUT, L_MDR, 0, 0, 0));
        sc("st_t7", ev(0, 0, 0, B_MDR, 0, M_WR));
        sc("st_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // br not taken, then taken
        IR = ins(5'd18);
        Con_FF = 1'b0;
        fetch("brn");
        sc("brn_t3", ev(GA, R_OUT, L_CON, 0, 0, 0));
        sc("brn_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        Con_FF = 1'b1;
        fetch("brt");
        sc("brt_t3", ev(GA, R_OUT, L_CON, 0, 0, 0));
        sc("brt_t4", ev(0, 0, L_Y, B_PC, 0, 0));
        sc("brt_t5", ev(0, 0, L_Z, B_C, 4'd1, 0));
        sc("brt_t6", ev(0, 0, L_PC, B_ZLO, 0, 0));
        sc("brt_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        Con_FF = 1'b0;

        // jal, not, shr, mfhi, unlisted opcode
        IR = ins(5'd20);
        fetch("jal");
        sc("jal_t3", ev(0, R_IN, 0, B_PC, 0, 0));
        sc("jal_t4", ev(GA, R_OUT, L_PC, 0, 0, 0));
        sc("jal_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        IR = ins(5'd17);
        fetch("not");
        sc("not_t3", ev(GB, R_OUT, L_Z, 0, 4'd12, 0));
        sc("not_t4", ev(GA, R_IN, 0, B_ZLO, 0, 0));
        sc("not_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        IR = ins(5'd5);
        fetch("shr");
        sc("shr_t3", ev(GB, R_OUT, L_Y, 0, 0, 0));
        sc("shr_t4", ev(0, 0, L_Z, B_C, 4'd5, 0));
        sc("shr_t5", ev(GA, R_IN, 0, B_ZLO, 0, 0));
        sc("shr_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        IR = ins(5'd23);
        fetch("mfhi");
        sc("mfhi_t3", ev(GA, R_IN, 0, B_HI, 0, 0));
        sc("mfhi_f0", ev(0, 0, L_MAR, B_PC, 0, 0));
        IR = ins(5'd25);
        fetch("nop");
        sc("nop_t3", ev(0, 0, 0, 0, 0, 0));
        sc("nop_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // sub with Stop raised mid-instruction
        IR = ins(5'd4);
        sc("sub_f1", ev(0, 0, L_MDR, 0, 0, M_INC | M_RD));
        Stop = 1'b1;
        sc("sub_f2", ev(0, 0, L_IR, B_MDR, 0, 0));
        sc("sub_t3", ev(GB, R_OUT, L_Y, 0, 0, 0));
        sc("sub_t4", ev(GC, R_OUT, L_Z, 0, 4'd2, 0));
        sc("sub_t5", ev(GA, R_IN, 0, B_ZLO, 0, 0));
        sc("stop_idle", 33'h0);
        sc("stop_hold", 33'h0);
        Stop = 1'b0;
        sc("stop_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // asynchronous reset mid-T4
        IR = ins(5'd3);
        fetch("rst");
        sc("rst_t3", ev(GB, R_OUT, L_Y, 0, 0, 0));
        sc("rst_t4", ev(GC, R_OUT, L_Z, 0, 4'd1, 0));
        #2 Reset_n = 1'b0;
        #1 chk("async_rst", 33'h0);
        step();
        Reset_n = 1'b1;
        sc("rst_f0", ev(0, 0, L_MAR, B_PC, 0, 0));

        // halt
        IR = ins(5'd26);
        fetch("halt");
        sc("halt_t3", ev(0, 0, 0, 0, 0, 0));
        sc("halt_in", 33'h0);
        step(); step();
        sc("halt_stay", 33'h0);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        sc("halt_exit", ev(0, 0, L_MAR, B_PC, 0, 0));

        // Mem_ready stuck low in F1
        Mem_ready = 1'b0;
        sc("to_f1a", ev(0, 0, L_MDR, 0, 0, M_INC | M_RD));
        for (int i = 2; i < 15; i++)
            step();
        sc("to_f1_15", ev(0, 0, L_MDR, 0, 0, M_RD));
`ifdef CU_MEM_TIMEOUT_EN
        sc("to_fault", 33'h1);
        step(); step();
        sc("to_fault_hold", 33'h1);
`else
        sc("to_f1_16", ev(0, 0, L_MDR, 0, 0, M_RD));
        for (int i = 0; i < 20; i++)
            step();
        sc("to_f1_37", ev(0, 0, L_MDR, 0, 0, M_RD));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
